// File: rtl/prior_sel_pkg.sv
// Shared types and helpers for the prior_sel arbiter family: FSM states,
// priority-direction constants and constant-evaluable utility functions.
package prior_sel_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int PRIO_MSB = 1;
    localparam int PRIO_LSB = -1;

    function automatic logic valToBool(input int v);
        return v != 0;
    endfunction

    // Smallest r with 2**r >= v; at least 1 so index ports never collapse.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prior_sel_arb_pick.sv
// Masked priority encoder: picks the highest-priority request inside mask,
// falling back to the unmasked requests when the masked set is empty.
module prior_sel_arb_pick
    import prior_sel_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic             direction,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] masked;

    function automatic logic [N-1:0] first_hot(input logic [N-1:0] v, input logic msb_first);
        logic [N-1:0] r;
        r = '0;
        if (msb_first) begin
            for (int i = 0; i < int'(N); i++) begin
                if (v[i]) begin
                    r    = '0;
                    r[i] = 1'b1;
                end
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (v[i]) begin
                    r    = '0;
                    r[i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    assign masked = req & mask;
    assign grant  = (|masked) ? first_hot(masked, direction) : first_hot(req, direction);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/prior_sel_arb.sv
// One-deep registered priority selector with valid/ready handshakes.
// Define PRIOR_SEL_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module prior_sel_arb
    import prior_sel_pkg::*;
#(
    parameter int unsigned BIT_WIDTH          = 2,
    parameter int unsigned SEL_SIG_NUMS       = 8,
    parameter int          PRIORITY_DIRECTION = 1,
    parameter int          DEFAULT_INPUT_EN   = 0,
    localparam int unsigned DEF   = valToBool(DEFAULT_INPUT_EN) ? 1 : 0,
    localparam int unsigned IDX_W = clog2(SEL_SIG_NUMS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [BIT_WIDTH*(SEL_SIG_NUMS+DEF)-1:0] in_data,
    input  logic [SEL_SIG_NUMS-1:0]                in_valid,
    output logic [SEL_SIG_NUMS-1:0]                in_ready,
    output logic [BIT_WIDTH-1:0]                   out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [SEL_SIG_NUMS-1:0]                out_grant,
    output logic [IDX_W-1:0]                       out_idx
);

    localparam logic DIR_MSB = (PRIORITY_DIRECTION >= 0);

    state_t                  state_q;
    state_t                  state_d;
    logic [SEL_SIG_NUMS-1:0] mask;
    logic [SEL_SIG_NUMS-1:0] grant;
    logic [IDX_W-1:0]        idx;
    logic [BIT_WIDTH-1:0]    lane_sel;
    logic [BIT_WIDTH-1:0]    dflt_lane;
    logic [BIT_WIDTH-1:0]    data_d;
    logic [SEL_SIG_NUMS-1:0] grant_d;
    logic [IDX_W-1:0]        idx_d;
    logic                    space;
    logic                    load;

    assign space     = (state_q == EMPTY) || out_ready;
    assign load      = space && (|in_valid);
    assign in_ready  = grant & {SEL_SIG_NUMS{space && !rst}};
    assign out_valid = (state_q == FULL);

`ifdef PRIOR_SEL_ARB_ROUND_ROBIN_EN
    // Reset pointer leaves the mask empty so the first search covers all requesters.
    localparam logic [IDX_W-1:0] PTR_RST = DIR_MSB ? '0 : IDX_W'(SEL_SIG_NUMS - 1);

    logic [IDX_W-1:0] ptr_q;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < SEL_SIG_NUMS; i++) begin
            mask[i] = DIR_MSB ? (IDX_W'(i) < ptr_q) : (IDX_W'(i) > ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       ptr_q <= PTR_RST;
        else if (load) ptr_q <= idx;
    end
`else
    assign mask = '1;
`endif

    prior_sel_arb_pick #(
        .N     (SEL_SIG_NUMS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (in_valid),
        .mask      (mask),
        .direction (DIR_MSB),
        .grant     (grant),
        .idx       (idx)
    );

    always_comb begin
        lane_sel = '0;
        for (int unsigned i = 0; i < SEL_SIG_NUMS; i++) begin
            lane_sel = lane_sel | (in_data[i*BIT_WIDTH +: BIT_WIDTH] & {BIT_WIDTH{grant[i]}});
        end
    end

    // Without a default lane the idle value is simply the held output.
    if (DEF != 0) begin : g_dflt
        assign dflt_lane = in_data[SEL_SIG_NUMS*BIT_WIDTH +: BIT_WIDTH];
    end else begin : g_hold
        assign dflt_lane = out_data;
    end

    always_comb begin
        state_d = state_q;
        data_d  = out_data;
        grant_d = out_grant;
        idx_d   = out_idx;
        if (load) begin
            state_d = FULL;
            data_d  = lane_sel;
            grant_d = grant;
            idx_d   = idx;
        end else if (space) begin
            state_d = EMPTY;
            data_d  = dflt_lane;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            out_data  <= '0;
            out_grant <= '0;
            out_idx   <= '0;
        end else begin
            state_q   <= state_d;
            out_data  <= data_d;
            out_grant <= grant_d;
            out_idx   <= idx_d;
        end
    end

endmodule

// File: tb/tb_prior_sel_arb.sv
// Directed table-driven bench: an MSB-priority instance and an LSB-priority
// instance with a default lane share the same handshake stimulus.
module tb_prior_sel_arb;
    import prior_sel_pkg::*;

    localparam int NV = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic        out_ready;
    logic [31:0] lanes;
    logic [39:0] lanes_d;

    logic [3:0] rdy_m, gnt_m, rdy_l, gnt_l;
    logic [7:0] od_m, od_l;
    logic       ov_m, ov_l;
    logic [1:0] idx_m, idx_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prior_sel_arb #(
        .BIT_WIDTH(8), .SEL_SIG_NUMS(4), .PRIORITY_DIRECTION(PRIO_MSB), .DEFAULT_INPUT_EN(0)
    ) u_msb (
        .clk(clk), .rst(rst), .in_data(lanes), .in_valid(in_valid), .in_ready(rdy_m),
        .out_data(od_m), .out_valid(ov_m), .out_ready(out_ready), .out_grant(gnt_m), .out_idx(idx_m)
    );

    prior_sel_arb #(
        .BIT_WIDTH(8), .SEL_SIG_NUMS(4), .PRIORITY_DIRECTION(PRIO_LSB), .DEFAULT_INPUT_EN(1)
    ) u_lsb (
        .clk(clk), .rst(rst), .in_data(lanes_d), .in_valid(in_valid), .in_ready(rdy_l),
        .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready), .out_grant(gnt_l), .out_idx(idx_l)
    );

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic [1:0] idx;
        logic [3:0] gnt;
        logic       lchk;
        logic       lov;
        logic [7:0] lod;
        logic [3:0] lgnt;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                                input logic [3:0] rd, input logic ov, input logic [7:0] od,
                                input logic [1:0] ix, input logic [3:0] g, input logic lc,
                                input logic lov, input logic [7:0] lod, input logic [3:0] lg);
        vec_t t;
        t.rst = r;  t.vld = v;  t.ordy = o; t.rdy = rd; t.ov = ov; t.od = od;
        t.idx = ix; t.gnt = g;  t.lchk = lc; t.lov = lov; t.lod = lod; t.lgnt = lg;
        return t;
    endfunction

    task automatic chk(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic step(input int n, input logic r, input logic [3:0] v, input logic o,
                        input logic [3:0] rd, input logic ov, input logic [7:0] od,
                        input logic [1:0] ix, input logic [3:0] g);
        rst = r; in_valid = v; out_ready = o;
        #1;
        chk("in_ready", n, 8'(rdy_m), 8'(rd));
        @(posedge clk);
        #1;
        chk("out_valid", n, 8'(ov_m), 8'(ov));
        chk("out_data", n, od_m, od);
        chk("out_idx", n, 8'(idx_m), 8'(ix));
        chk("out_grant", n, 8'(gnt_m), 8'(g));
    endtask

    initial begin
        lanes   = 32'h4433_2211;
        lanes_d = {8'hAA, 32'h4433_2211};

        tv[0]  = mk(1, 4'b0101, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 1, 0, 8'h00, 4'b0000);
        tv[1]  = mk(0, 4'b0101, 1, 4'b0100, 1, 8'h33, 2, 4'b0100, 1, 1, 8'h11, 4'b0001);
        tv[2]  = mk(0, 4'b1111, 0, 4'b0000, 1, 8'h33, 2, 4'b0100, 0, 0, 8'h00, 4'b0000);
        tv[3]  = tv[2];
        tv[4]  = tv[2];
`ifdef PRIOR_SEL_ARB_ROUND_ROBIN_EN
        tv[5]  = mk(0, 4'b1111, 1, 4'b0010, 1, 8'h22, 1, 4'b0010, 0, 0, 8'h00, 4'b0000);
        tv[6]  = mk(0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0, 4'b0001, 0, 0, 8'h00, 4'b0000);
        tv[7]  = mk(0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3, 4'b1000, 0, 0, 8'h00, 4'b0000);
`else
        tv[5]  = mk(0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3, 4'b1000, 0, 0, 8'h00, 4'b0000);
        tv[6]  = tv[5];
        tv[7]  = tv[5];
`endif
        tv[8]  = mk(0, 4'b0000, 1, 4'b0000, 0, 8'h44, 3, 4'b0000, 1, 0, 8'hAA, 4'b0000);
        tv[9]  = mk(0, 4'b0000, 0, 4'b0000, 0, 8'h44, 3, 4'b0000, 0, 0, 8'h00, 4'b0000);
        tv[10] = mk(0, 4'b0010, 0, 4'b0010, 1, 8'h22, 1, 4'b0010, 0, 0, 8'h00, 4'b0000);
        tv[11] = mk(1, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 4'b0000, 1, 0, 8'h00, 4'b0000);
        tv[12] = mk(0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3, 4'b1000, 1, 1, 8'h11, 4'b0001);
`ifdef PRIOR_SEL_ARB_ROUND_ROBIN_EN
        tv[13] = mk(0, 4'b1111, 1, 4'b0100, 1, 8'h33, 2, 4'b0100, 0, 0, 8'h00, 4'b0000);
        tv[14] = mk(0, 4'b1111, 1, 4'b0010, 1, 8'h22, 1, 4'b0010, 0, 0, 8'h00, 4'b0000);
        tv[15] = mk(0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0, 4'b0001, 0, 0, 8'h00, 4'b0000);
`else
        tv[13] = mk(0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3, 4'b1000, 0, 0, 8'h00, 4'b0000);
        tv[14] = tv[13];
        tv[15] = tv[13];
`endif
        tv[16] = mk(0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3, 4'b1000, 0, 0, 8'h00, 4'b0000);
        tv[17] = mk(0, 4'b0001, 1, 4'b0001, 1, 8'h11, 0, 4'b0001, 0, 0, 8'h00, 4'b0000);
        tv[18] = mk(0, 4'b1001, 0, 4'b0000, 1, 8'h11, 0, 4'b0001, 0, 0, 8'h00, 4'b0000);
        tv[19] = mk(0, 4'b0000, 1, 4'b0000, 0, 8'h11, 0, 4'b0000, 0, 0, 8'h00, 4'b0000);

        rst = 1'b1; in_valid = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int n = 0; n < NV; n++) begin
            rst = tv[n].rst; in_valid = tv[n].vld; out_ready = tv[n].ordy;
            #1;
            chk("in_ready", n, 8'(rdy_m), 8'(tv[n].rdy));
            if (n == 1) chk("lsb_in_ready", n, 8'(rdy_l), 8'h01);
            @(posedge clk);
            #1;
            chk("out_valid", n, 8'(ov_m), 8'(tv[n].ov));
            chk("out_data", n, od_m, tv[n].od);
            chk("out_idx", n, 8'(idx_m), 8'(tv[n].idx));
            chk("out_grant", n, 8'(gnt_m), 8'(tv[n].gnt));
            if (tv[n].lchk) begin
                chk("lsb_out_valid", n, 8'(ov_l), 8'(tv[n].lov));
                chk("lsb_out_data", n, od_l, tv[n].lod);
                chk("lsb_out_grant", n, 8'(gnt_l), 8'(tv[n].lgnt));
            end
        end

        // Requests change while stalled; the release cycle re-arbitrates the new set.
        step(100, 0, 4'b0001, 0, 4'b0001, 1, 8'h11, 0, 4'b0001);
        step(101, 0, 4'b1000, 0, 4'b0000, 1, 8'h11, 0, 4'b0001);
        step(102, 0, 4'b0100, 1, 4'b0100, 1, 8'h33, 2, 4'b0100);
        step(103, 0, 4'b0000, 1, 4'b0000, 0, 8'h33, 2, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
